writeback_stage: RTL and testbench
==================================

WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 The block SHALL be a single-clock design on clk; reset is asynchronous and active-high, port rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 in_valid  input  1  upstream (memory stage) entry present.
REQ-005 in_ready  output  1  stage accepts an entry this cycle.
REQ-006 in_alu_result  input  32  ALU result.
REQ-007 in_mem_data  input  32  raw aligned memory word.
REQ-008 in_dest  input  6  destination register index, matching register-file index width.
REQ-009 in_reg_write  input  1  entry writes a register.
REQ-010 in_mem_to_reg  input  1  1 = take load data, 0 = take ALU result.
REQ-011 in_load_size  input  2  00 word, 01 halfword, 10 byte, 11 reserved.
REQ-012 in_load_unsigned  input  1  1 = zero-extend, 0 = sign-extend.
REQ-013 in_byte_off  input  2  byte address bits [1:0] of the load.
REQ-014 flush  input  1  synchronous discard of the held entry.
REQ-015 rf_hold  input  1  register file cannot take a write this cycle.
REQ-016 wdat  output  32  write data to register file.
REQ-017 wreg  output  6  write register index to register file.
REQ-018 reg_write  output  1  single-cycle write strobe to register file.
REQ-019 fwd_valid, fwd_reg(6), fwd_data(32)  output  forwarding view of the held entry.
REQ-020 align_err  output  1  one-cycle pulse on retiring a misaligned load.
REQ-021 retire_count  output  32  retired-entry counter.

Function
REQ-022 The stage SHALL hold one entry; state EMPTY or FULL.
REQ-023 in_ready SHALL equal (EMPTY or not rf_hold) and not flush.
REQ-024 An entry SHALL be accepted at the rising edge when in_valid and in_ready are both high; all fields are registered at that edge.
REQ-025 A held entry SHALL retire in any cycle where the stage is FULL, rf_hold=0 and flush=0.
REQ-026 State transitions: EMPTY→FULL on accept; FULL→FULL on retire plus same-cycle accept; FULL→EMPTY on retire with no accept; FULL holds while rf_hold=1.
REQ-027 flush=1 SHALL force EMPTY at the next edge, drop the held entry without retiring it, and accept nothing; flush has priority over rf_hold and in_valid.
REQ-028 Latency: an entry accepted at edge E with rf_hold=0 SHALL drive reg_write in the cycle immediately after E; back-to-back throughput is one entry per cycle.
REQ-029 Byte lane SHALL be in_mem_data[8*off+7:8*off]; halfword lane SHALL be [31:16] for off=2 and [15:0] for off=0.
REQ-030 Byte/halfword SHALL be extended to 32 bits per in_load_unsigned; word SHALL pass unchanged.
REQ-031 A load is misaligned when word with off≠0, halfword with off odd, or load_size=11.
REQ-032 wdat SHALL be the formatted load data when mem_to_reg=1, else the ALU result; wreg SHALL be the held dest.
REQ-033 reg_write SHALL be high only in a retire cycle with held reg_write=1, dest in 1..31 and no misalignment.
REQ-034 dest=0 or dest≥32 SHALL suppress the write silently; the entry still retires and counts.
REQ-035 align_err SHALL pulse in the retire cycle of a misaligned load (mem_to_reg=1); the write is suppressed.
REQ-036 fwd_valid SHALL equal FULL and held reg_write and dest in 1..31 and not misaligned, independent of rf_hold; fwd_reg=wreg, fwd_data=wdat.
REQ-037 retire_count SHALL increment by 1 per retire and wrap from 0xFFFFFFFF to 0.

Reset
REQ-038 rst SHALL immediately force EMPTY, retire_count=0 and all held fields to 0, so that wdat=0, wreg=0, reg_write=0, fwd_valid=0 and align_err=0.
REQ-039 An entry held when rst asserts SHALL be discarded without a write; in_ready SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-040 Accept ALU entry (alu=0x12345678, dest=9, reg_write=1) with rf_hold=0 -> next cycle reg_write=1, wreg=9, wdat=0x12345678, retire_count=1.
REQ-041 Signed byte load with mem_data=0x80FF7F01 and off=3 -> wdat=0xFFFFFF80; with unsigned=1 -> wdat=0x00000080; unsigned halfword with off=2 -> wdat=0x000080FF.
REQ-042 Word load with off=1 -> align_err=1 and reg_write=0 in the retire cycle; retire_count still increments.
REQ-043 Hold the entry with rf_hold=1 for 3 cycles while in_valid=1 -> in_ready=0, reg_write=0, fwd_valid=1; on release the entry retires and the next input is accepted in the same cycle.
REQ-044 With dest=0 and reg_write=1 -> reg_write stays 0 and fwd_valid=0; flush while FULL -> no write, EMPTY next cycle, count unchanged.
REQ-045 Preload retire_count=0xFFFFFFFF, then retire one entry -> retire_count=0; assert rst mid-hold -> all outputs are 0 immediately.

Source files
------------

// File: rtl/writeback_stage.sv
// writeback_stage: single-entry writeback buffer between the memory stage and
// the register file. It formats load data by size, offset and signedness, flags
// misaligned loads, drives the register-file write port and a forwarding view
// of the held entry, and counts retired entries.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   in_valid/in_ready   upstream handshake (accept when both high)
//   in_alu_result       ALU result
//   in_mem_data         raw aligned memory word
//   in_dest             destination register index
//   in_reg_write        entry writes a register
//   in_mem_to_reg       select load data (1) or ALU result (0)
//   in_load_size        00 word, 01 halfword, 10 byte, 11 reserved
//   in_load_unsigned    zero-extend (1) or sign-extend (0)
//   in_byte_off         byte address bits [1:0] of the load
//   flush               discard the held entry without retiring it
//   rf_hold             register file cannot take a write this cycle
//   wdat, wreg          register-file write data / index
//   reg_write           single-cycle register-file write strobe
//   fwd_valid/reg/data  forwarding view of the held entry
//   align_err           pulse when a misaligned load retires
//   retire_count        wrapping count of retired entries
module writeback_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_alu_result,
   input  logic [31:0] in_mem_data,
   input  logic [5:0]  in_dest,
   input  logic        in_reg_write,
   input  logic        in_mem_to_reg,
   input  logic [1:0]  in_load_size,
   input  logic        in_load_unsigned,
   input  logic [1:0]  in_byte_off,
   input  logic        flush,
   input  logic        rf_hold,
   output logic [31:0] wdat,
   output logic [5:0]  wreg,
   output logic        reg_write,
   output logic        fwd_valid,
   output logic [5:0]  fwd_reg,
   output logic [31:0] fwd_data,
   output logic        align_err,
   output logic [31:0] retire_count
);

   localparam int unsigned DATA_W = 32;
   localparam int unsigned REG_W  = 6;

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   alu_q, alu_d;
   logic [DATA_W-1:0]   mem_q, mem_d;
   logic [REG_W-1:0]    dest_q, dest_d;
   logic                rw_q, rw_d;
   logic                m2r_q, m2r_d;
   logic [1:0]          size_q, size_d;
   logic                uns_q, uns_d;
   logic [1:0]          off_q, off_d;
   logic [DATA_W-1:0]   count_q, count_d;

   logic                accept;
   logic                retire;
   logic [7:0]          byte_lane;
   logic [15:0]         half_lane;
   logic [DATA_W-1:0]   load_data;
   logic                misaligned;
   logic                dest_ok;

   // State and held-entry registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= EMPTY;
         alu_q   <= '0;
         mem_q   <= '0;
         dest_q  <= '0;
         rw_q    <= 1'b0;
         m2r_q   <= 1'b0;
         size_q  <= '0;
         uns_q   <= 1'b0;
         off_q   <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         alu_q   <= alu_d;
         mem_q   <= mem_d;
         dest_q  <= dest_d;
         rw_q    <= rw_d;
         m2r_q   <= m2r_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         off_q   <= off_d;
         count_q <= count_d;
      end
   end

   // Handshake, next state and capture of an accepted entry
   always_comb begin
      state_d = state_q;
      alu_d   = alu_q;
      mem_d   = mem_q;
      dest_d  = dest_q;
      rw_d    = rw_q;
      m2r_d   = m2r_q;
      size_d  = size_q;
      uns_d   = uns_q;
      off_d   = off_q;
      count_d = count_q;

      // flush blocks acceptance so a flushed cycle can never refill the slot
      in_ready = ((state_q == EMPTY) || !rf_hold) && !flush;
      accept   = in_valid && in_ready;
      retire   = (state_q == FULL) && !rf_hold && !flush;

      if (flush) begin
         state_d = EMPTY;
      end else if (accept) begin
         state_d = FULL;
      end else if (retire) begin
         state_d = EMPTY;
      end

      if (accept) begin
         alu_d  = in_alu_result;
         mem_d  = in_mem_data;
         dest_d = in_dest;
         rw_d   = in_reg_write;
         m2r_d  = in_mem_to_reg;
         size_d = in_load_size;
         uns_d  = in_load_unsigned;
         off_d  = in_byte_off;
      end

      if (retire) begin
         count_d = count_q + DATA_W'(1);
      end
   end

   // Load formatting and write qualification from the held entry
   always_comb begin
      case (off_q)
         2'd0:    byte_lane = mem_q[7:0];
         2'd1:    byte_lane = mem_q[15:8];
         2'd2:    byte_lane = mem_q[23:16];
         default: byte_lane = mem_q[31:24];
      endcase
      // odd halfword offsets are misaligned, so only off[1] picks the lane
      half_lane = off_q[1] ? mem_q[31:16] : mem_q[15:0];

      case (size_q)
         2'b01:   load_data = {{16{!uns_q && half_lane[15]}}, half_lane};
         2'b10:   load_data = {{24{!uns_q && byte_lane[7]}}, byte_lane};
         default: load_data = mem_q;
      endcase

      misaligned = m2r_q && ((size_q == 2'b11) ||
                             ((size_q == 2'b00) && (off_q != 2'd0)) ||
                             ((size_q == 2'b01) && off_q[0]));
      // legal destinations are 1..31: bit 5 clear and not register 0
      dest_ok    = !dest_q[5] && (dest_q[4:0] != 5'd0);

      wdat         = m2r_q ? load_data : alu_q;
      wreg         = dest_q;
      fwd_valid    = (state_q == FULL) && rw_q && dest_ok && !misaligned;
      reg_write    = retire && rw_q && dest_ok && !misaligned;
      align_err    = retire && misaligned;
      fwd_reg      = wreg;
      fwd_data     = wdat;
      retire_count = count_q;
   end

endmodule

// File: tb/tb_writeback_stage.sv
// Randomized scoreboard bench for writeback_stage: the driver pushes the
// expected writeback of every accepted entry; a negedge monitor pops and
// compares it when the entry retires or is flushed.
module tb_writeback_stage;

   typedef struct packed {
      logic [31:0] alu;
      logic [31:0] mem;
      logic [5:0]  dest;
      logic        rw;
      logic        m2r;
      logic [1:0]  size;
      logic        uns;
      logic [1:0]  off;
   } entry_t;

   typedef struct packed {
      logic        we;
      logic [5:0]  wreg;
      logic [31:0] wdat;
      logic        chk_wdat;
      logic        align;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_alu_result;
   logic [31:0] in_mem_data;
   logic [5:0]  in_dest;
   logic        in_reg_write;
   logic        in_mem_to_reg;
   logic [1:0]  in_load_size;
   logic        in_load_unsigned;
   logic [1:0]  in_byte_off;
   logic        flush;
   logic        rf_hold;
   logic [31:0] wdat;
   logic [5:0]  wreg;
   logic        reg_write;
   logic        fwd_valid;
   logic [5:0]  fwd_reg;
   logic [31:0] fwd_data;
   logic        align_err;
   logic [31:0] retire_count;

   int          n_checks = 0;
   int          n_fail   = 0;
   exp_t        sb[$];
   logic [31:0] exp_count = 32'd0;

   writeback_stage dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_alu_result(in_alu_result), .in_mem_data(in_mem_data),
      .in_dest(in_dest), .in_reg_write(in_reg_write),
      .in_mem_to_reg(in_mem_to_reg), .in_load_size(in_load_size),
      .in_load_unsigned(in_load_unsigned), .in_byte_off(in_byte_off),
      .flush(flush), .rf_hold(rf_hold), .wdat(wdat), .wreg(wreg),
      .reg_write(reg_write), .fwd_valid(fwd_valid), .fwd_reg(fwd_reg),
      .fwd_data(fwd_data), .align_err(align_err), .retire_count(retire_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, want, $time);
      end
   endtask

   // Reference: load formatting from the rules as plain integer arithmetic
   function automatic exp_t model(input entry_t e);
      exp_t        r;
      longint      v;
      logic        mis;
      mis = e.m2r && ((e.size == 2'd3) || (e.size == 2'd0 && e.off != 2'd0) ||
                      (e.size == 2'd1 && (e.off % 2) == 1));
      v = longint'(e.mem);
      if (e.size == 2'd2) begin
         v = (v >> (8 * int'(e.off))) % 256;
         if (!e.uns && v >= 128) v = v - 256;
      end else if (e.size == 2'd1) begin
         v = (v >> (8 * int'(e.off))) % 65536;
         if (!e.uns && v >= 32768) v = v - 65536;
      end
      r.wdat     = e.m2r ? 32'(v) : e.alu;
      r.chk_wdat = !mis;
      r.wreg     = e.dest;
      r.align    = mis;
      r.we       = e.rw && (e.dest >= 6'd1) && (e.dest <= 6'd31) && !mis;
      return r;
   endfunction

   // One cycle of stimulus; the expected result is queued if the DUT takes it
   task automatic step(input logic v, input entry_t e, input logic fl, input logic hold);
      @(posedge clk);
      #1;
      in_valid = v;  in_alu_result = e.alu;  in_mem_data = e.mem;
      in_dest = e.dest;  in_reg_write = e.rw;  in_mem_to_reg = e.m2r;
      in_load_size = e.size;  in_load_unsigned = e.uns;  in_byte_off = e.off;
      flush = fl;  rf_hold = hold;
      @(negedge clk);
      #1;
      if (in_valid && in_ready) sb.push_back(model(e));
   endtask

   function automatic entry_t mk(input logic [31:0] alu, input logic [31:0] mem,
                                 input logic [5:0] dest, input logic rw, input logic m2r,
                                 input logic [1:0] size, input logic uns, input logic [1:0] off);
      entry_t e;
      e.alu = alu; e.mem = mem; e.dest = dest; e.rw = rw; e.m2r = m2r;
      e.size = size; e.uns = uns; e.off = off;
      return e;
   endfunction

   // Monitor: compares outputs against the head of the scoreboard each cycle
   always @(negedge clk) begin
      logic full;
      exp_t h;
      if (rst) begin
         sb.delete();
         exp_count = 32'd0;
         check("rst_reg_write", 32'(reg_write), 32'd0);
         check("rst_fwd_valid", 32'(fwd_valid), 32'd0);
         check("rst_count", retire_count, 32'd0);
      end else begin
         full = (sb.size() != 0);
         h = full ? sb[0] : '0;
         check("in_ready", 32'(in_ready), 32'((!full || !rf_hold) && !flush));
         check("fwd_valid", 32'(fwd_valid), 32'(full && h.we));
         check("retire_count", retire_count, exp_count);
         if (full) begin
            check("wreg", 32'(wreg), 32'(h.wreg));
            check("fwd_reg", 32'(fwd_reg), 32'(h.wreg));
            if (h.chk_wdat) begin
               check("wdat", wdat, h.wdat);
               check("fwd_data", fwd_data, h.wdat);
            end
         end
         if (full && !flush && !rf_hold) begin
            check("reg_write", 32'(reg_write), 32'(h.we));
            check("align_err", 32'(align_err), 32'(h.align));
            void'(sb.pop_front());
            exp_count = exp_count + 32'd1;
         end else begin
            check("reg_write_idle", 32'(reg_write), 32'd0);
            check("align_err_idle", 32'(align_err), 32'd0);
            if (full && flush) void'(sb.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected done");
      $fatal(1, "watchdog");
   end

   initial begin
      entry_t z, e;
      z = '0;
      rst = 1'b1;  in_valid = 1'b0;  in_alu_result = '0;  in_mem_data = '0;
      in_dest = '0;  in_reg_write = 1'b0;  in_mem_to_reg = 1'b0;
      in_load_size = '0;  in_load_unsigned = 1'b0;  in_byte_off = '0;
      flush = 1'b0;  rf_hold = 1'b0;
      #12;
      check("reset_wdat", wdat, 32'd0);
      check("reset_wreg", 32'(wreg), 32'd0);
      check("reset_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1 rst = 1'b0;

      // ALU entry, then byte/halfword loads and a misaligned word load
      step(1'b1, mk(32'h1234_5678, 32'h0, 6'd9, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0), 1'b0, 1'b0);
      step(1'b1, mk(32'h0, 32'h80FF_7F01, 6'd3, 1'b1, 1'b1, 2'd2, 1'b0, 2'd3), 1'b0, 1'b0);
      step(1'b1, mk(32'h0, 32'h80FF_7F01, 6'd4, 1'b1, 1'b1, 2'd2, 1'b1, 2'd3), 1'b0, 1'b0);
      step(1'b1, mk(32'h0, 32'h80FF_7F01, 6'd5, 1'b1, 1'b1, 2'd1, 1'b1, 2'd2), 1'b0, 1'b0);
      step(1'b1, mk(32'h0, 32'hDEAD_BEEF, 6'd6, 1'b1, 1'b1, 2'd0, 1'b0, 2'd1), 1'b0, 1'b0);
      // held for three cycles under rf_hold, then released with a new input
      e = mk(32'hCAFE_0001, 32'h0, 6'd7, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0);
      step(1'b1, e, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b1, e, 1'b0, 1'b1);
      step(1'b1, mk(32'hCAFE_0002, 32'h0, 6'd8, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0), 1'b0, 1'b0);
      // dest 0 and dest >= 32 suppress the write; flush drops a held entry
      step(1'b1, mk(32'h1111_1111, 32'h0, 6'd0, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0), 1'b0, 1'b0);
      step(1'b1, mk(32'h2222_2222, 32'h0, 6'd40, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0), 1'b0, 1'b0);
      step(1'b1, mk(32'h3333_3333, 32'h0, 6'd10, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0), 1'b0, 1'b1);
      step(1'b1, mk(32'h4444_4444, 32'h0, 6'd11, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0), 1'b1, 1'b1);
      step(1'b0, z, 1'b0, 1'b0);
      step(1'b0, z, 1'b0, 1'b0);

      // counter wrap from all ones
      force dut.count_q = 32'hFFFF_FFFF;
      #1 release dut.count_q;
      exp_count = 32'hFFFF_FFFF;
      step(1'b1, mk(32'h5555_5555, 32'h0, 6'd12, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0), 1'b0, 1'b0);
      step(1'b0, z, 1'b0, 1'b0);
      step(1'b0, z, 1'b0, 1'b0);
      check("count_wrapped", retire_count, 32'd0);

      // reset while an entry is held: outputs clear immediately
      step(1'b1, mk(32'h6666_6666, 32'h0, 6'd13, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0), 1'b0, 1'b1);
      step(1'b0, z, 1'b0, 1'b1);
      @(posedge clk); #1;
      rst = 1'b1;  rf_hold = 1'b0;
      #1;
      check("rst_now_wdat", wdat, 32'd0);
      check("rst_now_wreg", 32'(wreg), 32'd0);
      check("rst_now_reg_write", 32'(reg_write), 32'd0);
      check("rst_now_fwd_valid", 32'(fwd_valid), 32'd0);
      check("rst_now_align_err", 32'(align_err), 32'd0);
      check("rst_now_count", retire_count, 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      step(1'b1, mk(32'h7777_7777, 32'h0, 6'd14, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0), 1'b0, 1'b0);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         e.alu  = $urandom;
         e.mem  = $urandom;
         e.dest = 6'($urandom_range(0, 40));
         e.rw   = ($urandom_range(0, 3) != 0);
         e.m2r  = 1'($urandom);
         e.size = 2'($urandom);
         e.uns  = 1'($urandom);
         e.off  = 2'($urandom);
         step(($urandom_range(0, 3) != 0), e, ($urandom_range(0, 11) == 0),
              ($urandom_range(0, 3) == 0));
      end
      step(1'b0, z, 1'b0, 1'b0);
      step(1'b0, z, 1'b0, 1'b0);
      check("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
